// File: rtl/cu_sequencer.sv
// Control-unit T-state sequencer: binary state counter with clear, one-hot jump
// load (encoded back to binary with a validity check) and increment with wrap.
module cu_sequencer #(
  parameter int N      = 6,
  parameter int states = 40
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              load,
  input  logic [states-1:0] load_onehot,
  input  logic              inc,
  output logic [N-1:0]      counter_value,
  output logic              wrap,
  output logic              load_err
);

  localparam logic [N-1:0] LAST_STATE = N'(states - 1);

  logic [N-1:0] count_q, count_d;
  logic         wrap_q, wrap_d;
  logic         load_err_q, load_err_d;

  logic         hit_seen;
  logic         multi_hit;
  logic [N-1:0] hit_idx;
  logic         onehot_ok;

  // One-hot to binary encoder; a second set bit marks the target as invalid.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    hit_seen  = 1'b0;
    multi_hit = 1'b0;
    hit_idx   = '0;
    for (int i = 0; i < states; i++) begin
      if (load_onehot[i]) begin
        // NOTE: blocking assignments here are intentional, each loop iteration
        // must see the value written by the previous one.
        multi_hit = multi_hit | hit_seen;
        hit_seen  = 1'b1;
        hit_idx   = N'(i);
      end
    end
    onehot_ok = hit_seen & ~multi_hit;
  end

  // Command priority: clr > load > inc > hold. Pulses default low every cycle.
  always_comb begin
    count_d    = count_q;
    wrap_d     = 1'b0;
    load_err_d = 1'b0;
    if (clr) begin
      count_d = '0;
    end else if (load) begin
      if (onehot_ok) begin
        count_d = hit_idx;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (inc) begin
      if (count_q == LAST_STATE) begin
        count_d = '0;
        wrap_d  = 1'b1;
      end else begin
        count_d = count_q + 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q    <= '0;
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
    end
  end

  assign counter_value = count_q;
  assign wrap          = wrap_q;
  assign load_err      = load_err_q;

endmodule

// File: doc/cu_sequencer.md
Name: cu_sequencer

Overview:
- Control-unit T-state sequencer: drives the binary `counter_value` bus consumed by the CU one-hot state decoder.
- The decoder turns that value into `CPU_state`.
- Also performs the reverse mapping: a one-hot jump target from the control logic is encoded back to binary and loaded.
- The loaded value redirects the CPU state sequence, e.g. for branches to a microstep or an early return to fetch.

Parameters:
- N, 6, width of `counter_value`; must satisfy 2**N >= states.
- states, 40, number of valid CPU states; legal count range 0..states-1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- clr  input  1  synchronous clear to state 0 (fetch).
- load  input  1  synchronous jump to the state encoded by `load_onehot`.
- load_onehot  input  states  one-hot jump target; bit i selects state i.
- inc  input  1  advance to the next state.
- counter_value  output  N  registered current state index; feeds the decoder.
- wrap  output  1  registered one-cycle pulse; the counter wrapped from states-1 to 0.
- load_err  output  1  registered one-cycle pulse; a load was rejected because `load_onehot` was not exactly one-hot.

Behaviour:
- Reset (async, rst=1): counter_value=0, wrap=0, load_err=0 immediately, independent of clk. Held while rst=1.
- Release of rst is sampled at the next rising edge as normal operation.
- Command priority per edge: clr > load > inc > hold.
- clr=1: counter_value<=0, wrap<=0, load_err<=0. Any simultaneous load or inc is ignored.
- load=1 (clr=0), valid target (exactly one bit of `load_onehot` set, at position k):
  - counter_value<=k, load_err<=0, wrap<=0.
  - inc is ignored that cycle.
- load=1 (clr=0), invalid target (zero bits set or two or more bits set):
  - counter_value holds, load_err<=1, wrap<=0.
  - inc is ignored that cycle.
- inc=1 (clr=0, load=0):
  - If counter_value==states-1: counter_value<=0, wrap<=1.
  - Otherwise: counter_value<=counter_value+1, wrap<=0.
- No command: counter_value holds; wrap<=0, load_err<=0.
- wrap and load_err are single-cycle pulses. They re-assert on consecutive cycles only if their condition recurs each cycle.
- Latency: one clock from command to new counter_value. Encoder validity check and index are combinational inside the block and registered at the edge.
- Invariant: counter_value never takes a value >= states.
- Encoder: popcount of `load_onehot` compared to 1; index = position of the single set bit.
  - Must be synthesizable for any states up to 2**N.
  - Built from a loop over all bit positions, with no latch and no default-dependent state.
- Round-trip requirement: decode(counter_value) after a valid load equals the `load_onehot` applied.

Test Plan:
- Async reset: drive inc high for 10 cycles, then assert rst between edges -> counter_value=0, wrap=0, load_err=0 before the next edge. Hold rst for 3 edges -> value stays 0.
- Count and wrap (N=6, states=40): inc high for 40 cycles from 0.
  - counter_value steps 0,1,...,39, then 0.
  - wrap=1 only in the cycle after 39→0.
  - No value ≥ 40 ever appears.
- Valid load: counter_value=5, load=1 with load_onehot=1<<23 -> next cycle counter_value=23, load_err=0. Then inc -> 24.
- Invalid load: counter_value=12.
  - load with load_onehot=0 -> value 12, load_err=1 for one cycle.
  - load with bits 3 and 7 set -> value 12, load_err=1.
  - load with bit 39 set -> value 39, load_err=0.
- Priority: at counter_value=39, assert clr, load (bit 10) and inc together -> 0, wrap=0. Then load (bit 10) plus inc together -> 10 (inc ignored).
- Exhaustive round-trip: for i=0..39, load 1<<i -> counter_value=i and load_err=0 on every load.
